pipeline_hazard_sequencer: RTL and testbench
============================================

Name: pipeline_hazard_sequencer

Overview:
- Parametrised, stateful successor of the core's combinational pipeline controller.
- Drives per-register enable and clear vectors for an N-stage in-order pipeline and the PC register enable.
- Adds multi-cycle load-use bubbles, a drain-then-flush interrupt-entry FSM, and a saturating flush counter.
- Sits in core/controllers, between the hazard unit, CSR/trap logic and the pipeline registers.

Parameters:
- NUM_STAGES, 5, pipeline stages; NUM_REGS = NUM_STAGES-1 inter-stage registers, index 0 = IF/ID, NUM_REGS-1 = MEM/WB.
- HAZ_REG, 1, register index that receives the load-use bubble (ID/EXE).
- LOAD_BUBBLES, 1, bubble cycles per load-use hazard (1..7).
- FLUSH_DEPTH, 3, registers 0..FLUSH_DEPTH-1 cleared on branch/mret.
- CNT_W, 16, flush counter width.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- stall_pipl  in  1  global memory stall.
- load_hazard  in  1  load-use hazard detected in ID.
- branch_hazard  in  1  taken branch/jump resolved.
- mret_type  in  1  mret retiring.
- irq_req  in  1  interrupt pending; level, held until irq_ack.
- hw_jump_clr  in  1  clear HAZ_REG only (hardware loop jump).
- stall_compressed  in  1  hold PC for compressed-fetch realignment.
- reg_en  out  NUM_REGS  per-register enable.
- reg_clr  out  NUM_REGS  per-register synchronous clear; clear beats enable inside the registers.
- pc_reg_en  out  1  PC enable.
- irq_ack  out  1  one-cycle pulse; pipeline flushed, trap may vector.
- flush_count  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Single clock domain; all state updates on the rising clk edge.
- Reset: FSM=IDLE, bubble_cnt=0, flush_count=0. While reset is high: reg_en=0, reg_clr=all ones, pc_reg_en=0, irq_ack=0.
- Mid-operation reset aborts any bubble or DRAIN immediately.
- Outputs are combinational from state and inputs; flush_count is registered.
- Bubble counter bubble_cnt (3 bits):
  - A load_hazard cycle with bubble_cnt==0 and no stall or flush loads LOAD_BUBBLES-1.
  - Each subsequent unstalled cycle decrements it.
  - bubble_active = load_hazard | (bubble_cnt!=0).
  - stall_pipl freezes the counter.
  - Any branch/mret/irq flush zeroes it.
- Output priority, highest first:
  - irq FLUSH state: reg_clr = all ones, reg_en = all ones, pc_reg_en=1, irq_ack=1.
  - branch_hazard | mret_type: reg_clr[FLUSH_DEPTH-1:0]=1, pc_reg_en=1, reg_en all ones, unless stall_pipl, which forces reg_en=0.
  - stall_pipl: reg_en=0, pc_reg_en=0, no clears except hw_jump_clr.
  - bubble_active: reg_en[HAZ_REG-1:0]=0, reg_en[NUM_REGS-1:HAZ_REG]=1, reg_clr[HAZ_REG]=1, pc_reg_en=0.
  - Otherwise: reg_en all ones, pc_reg_en = ~stall_compressed.
- hw_jump_clr ORs into reg_clr[HAZ_REG] in every state except reset.
- stall_compressed always forces pc_reg_en=0, except during flush rows.
- Interrupt FSM:
  - IDLE: irq_req=1 goes to DRAIN.
  - DRAIN: wait until stall_pipl=0 and bubble_active=0, then go to FLUSH. A branch/mret in DRAIN is serviced normally and the FSM stays in DRAIN.
  - FLUSH: exactly one cycle, then IDLE.
  - irq_req dropping while in DRAIN returns the FSM to IDLE without an ack.
- flush_count: increments by 1 on each cycle with branch_hazard | mret_type | FLUSH; saturates at all ones.
- Simultaneous branch_hazard and load_hazard: the branch wins and no bubble is started.

Decomposition:
- Shared package core_ctrl_pkg:
  - typedef enum {IRQ_IDLE, IRQ_DRAIN, IRQ_FLUSH} irq_seq_e.
  - localparam MAX_BUBBLES=7.
  - Index constants IF_ID, ID_EXE, EXE_MEM, MEM_WB.
- One sub-module, irq_flush_fsm: the DRAIN/FLUSH sequencer, with inputs irq_req, stall_pipl, bubble_active and outputs state, irq_ack.

Test Plan:
- Reset held 2 cycles -> reg_clr=4'b1111, reg_en=0, pc_reg_en=0. After release with idle inputs -> reg_en=4'b1111, pc_reg_en=1, flush_count=0.
- LOAD_BUBBLES=3, load_hazard for 1 cycle -> 3 consecutive cycles of pc_reg_en=0, reg_en=4'b1110, reg_clr=4'b0010. Cycle 4 back to normal.
- load_hazard plus stall_pipl for 2 cycles, then stall released (LOAD_BUBBLES=3) -> reg_en=0 and no clr during the stall; exactly 3 bubble cycles follow the release.
- irq_req asserted while stall_pipl=1 for 4 cycles -> FSM in DRAIN, irq_ack=0. First unstalled cycle -> FLUSH: reg_clr=4'b1111, irq_ack pulses once, flush_count=1.
- branch_hazard together with load_hazard -> reg_clr=4'b0111, pc_reg_en=1, no bubble next cycle, flush_count increments.
- CNT_W=2, 5 consecutive branch cycles -> flush_count sequence 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared types and constants
// for the core pipeline controllers.
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE,
    IRQ_DRAIN,
    IRQ_FLUSH
  } irq_seq_e;

  localparam int MAX_BUBBLES = 7;

  localparam int IF_ID   = 0;
  localparam int ID_EXE  = 1;
  localparam int EXE_MEM = 2;
  localparam int MEM_WB  = 3;

endpackage

// File: rtl/pipeline_hazard_sequencer_irq_fsm.sv
// irq_flush_fsm: waits for the pipeline to drain,
// then issues a single-cycle interrupt flush.
module irq_flush_fsm
  import core_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     irq_req,
  input  logic     stall_pipl,
  input  logic     bubble_active,
  input  logic     pipe_flush,
  output irq_seq_e state,
  output logic     irq_ack
);

  irq_seq_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IRQ_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IRQ_IDLE: begin
        if (irq_req) state_d = IRQ_DRAIN;
      end
      IRQ_DRAIN: begin
        // a branch/mret in flight is serviced first
        if (!irq_req) begin
          state_d = IRQ_IDLE;
        end else if (!stall_pipl && !bubble_active
                     && !pipe_flush) begin
          state_d = IRQ_FLUSH;
        end
      end
      IRQ_FLUSH: state_d = IRQ_IDLE;
      default:   state_d = IRQ_IDLE;
    endcase
  end

  assign state   = state_q;
  assign irq_ack = (state_q == IRQ_FLUSH);

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// pipeline_hazard_sequencer: per-register enable/clear
// control with load bubbles, irq flush and flush count.
module pipeline_hazard_sequencer
  import core_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 5,
  parameter int HAZ_REG      = ID_EXE,
  parameter int LOAD_BUBBLES = 1,
  parameter int FLUSH_DEPTH  = 3,
  parameter int CNT_W        = 16,
  localparam int NUM_REGS    = NUM_STAGES - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall_pipl,
  input  logic                load_hazard,
  input  logic                branch_hazard,
  input  logic                mret_type,
  input  logic                irq_req,
  input  logic                hw_jump_clr,
  input  logic                stall_compressed,
  output logic [NUM_REGS-1:0] reg_en,
  output logic [NUM_REGS-1:0] reg_clr,
  output logic                pc_reg_en,
  output logic                irq_ack,
  output logic [CNT_W-1:0]    flush_count
);

  localparam int BUB_N =
    (LOAD_BUBBLES > MAX_BUBBLES) ? MAX_BUBBLES :
    (LOAD_BUBBLES < 1) ? 1 : LOAD_BUBBLES;
  localparam logic [2:0] BUB_LOAD = 3'(BUB_N - 1);

  localparam logic [NUM_REGS-1:0] ALL_M = '1;
  localparam logic [NUM_REGS-1:0] HAZ_M =
    {{(NUM_REGS-1){1'b0}}, 1'b1} << HAZ_REG;
  localparam logic [NUM_REGS-1:0] BUB_EN_M =
    ALL_M << HAZ_REG;
  localparam logic [NUM_REGS-1:0] FLUSH_M =
    ALL_M >> (NUM_REGS - FLUSH_DEPTH);

  logic [2:0]       bub_cnt_q, bub_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bubble_active;
  logic             br_flush;
  logic             irq_flush;
  logic             any_flush;
  logic             fsm_ack;
  irq_seq_e         irq_state;

  assign br_flush      = branch_hazard | mret_type;
  assign irq_flush     = (irq_state == IRQ_FLUSH);
  assign any_flush     = br_flush | irq_flush;
  assign bubble_active = load_hazard | (bub_cnt_q != 3'd0);

  irq_flush_fsm u_irq_fsm (
    .clk           (clk),
    .reset         (reset),
    .irq_req       (irq_req),
    .stall_pipl    (stall_pipl),
    .bubble_active (bubble_active),
    .pipe_flush    (br_flush),
    .state         (irq_state),
    .irq_ack       (fsm_ack)
  );

  always_comb begin
    bub_cnt_d = bub_cnt_q;
    if (any_flush) begin
      bub_cnt_d = 3'd0;
    end else if (!stall_pipl) begin
      if (bub_cnt_q != 3'd0) begin
        bub_cnt_d = bub_cnt_q - 3'd1;
      end else if (load_hazard) begin
        bub_cnt_d = BUB_LOAD;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (any_flush && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bub_cnt_q <= 3'd0;
      cnt_q     <= '0;
    end else begin
      bub_cnt_q <= bub_cnt_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    reg_en    = ALL_M;
    reg_clr   = '0;
    pc_reg_en = 1'b1;
    irq_ack   = 1'b0;
    if (reset) begin
      reg_en    = '0;
      reg_clr   = ALL_M;
      pc_reg_en = 1'b0;
    end else if (irq_flush) begin
      reg_clr = ALL_M;
      irq_ack = fsm_ack;
    end else begin
      if (br_flush) begin
        reg_clr = FLUSH_M;
        reg_en  = stall_pipl ? '0 : ALL_M;
      end else if (stall_pipl) begin
        reg_en    = '0;
        pc_reg_en = 1'b0;
      end else if (bubble_active) begin
        reg_en    = BUB_EN_M;
        reg_clr   = HAZ_M;
        pc_reg_en = 1'b0;
      end else begin
        pc_reg_en = ~stall_compressed;
      end
      if (hw_jump_clr) reg_clr = reg_clr | HAZ_M;
    end
  end

  assign flush_count = cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// tb_pipeline_hazard_sequencer: directed plus random
// stimulus checked against a behavioural model.
module tb_pipeline_hazard_sequencer;

  logic       clk = 1'b0;
  logic       reset, stall_pipl, load_hazard;
  logic       branch_hazard, mret_type, irq_req;
  logic       hw_jump_clr, stall_compressed;
  logic [3:0] reg_en, reg_clr, reg_en2, reg_clr2;
  logic       pc_reg_en, irq_ack, pc_reg_en2, irq_ack2;
  logic [15:0] flush_count;
  logic [1:0]  flush_count2;

  int checks   = 0;
  int failures = 0;

  int bub_left = 0;
  bit draining = 0;
  bit flushing = 0;
  bit known    = 0;
  int fc16     = 0;
  int fc2      = 0;
  bit last_ack = 0;

  logic [3:0] obs_en, obs_clr;
  logic       obs_pc, obs_ack;
  logic [15:0] obs_cnt;
  logic [1:0]  obs_cnt2;

  always #5 clk = ~clk;

  pipeline_hazard_sequencer #(
    .LOAD_BUBBLES (3),
    .CNT_W        (16)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .stall_pipl       (stall_pipl),
    .load_hazard      (load_hazard),
    .branch_hazard    (branch_hazard),
    .mret_type        (mret_type),
    .irq_req          (irq_req),
    .hw_jump_clr      (hw_jump_clr),
    .stall_compressed (stall_compressed),
    .reg_en           (reg_en),
    .reg_clr          (reg_clr),
    .pc_reg_en        (pc_reg_en),
    .irq_ack          (irq_ack),
    .flush_count      (flush_count)
  );

  pipeline_hazard_sequencer #(
    .LOAD_BUBBLES (3),
    .CNT_W        (2)
  ) dut2 (
    .clk              (clk),
    .reset            (reset),
    .stall_pipl       (stall_pipl),
    .load_hazard      (load_hazard),
    .branch_hazard    (branch_hazard),
    .mret_type        (mret_type),
    .irq_req          (irq_req),
    .hw_jump_clr      (hw_jump_clr),
    .stall_compressed (stall_compressed),
    .reg_en           (reg_en2),
    .reg_clr          (reg_clr2),
    .pc_reg_en        (pc_reg_en2),
    .irq_ack          (irq_ack2),
    .flush_count      (flush_count2)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic drv(input bit r, input bit s,
                     input bit l, input bit b,
                     input bit m, input bit i,
                     input bit h, input bit c);
    reset            = r;
    stall_pipl       = s;
    load_hazard      = l;
    branch_hazard    = b;
    mret_type        = m;
    irq_req          = i;
    hw_jump_clr      = h;
    stall_compressed = c;
  endtask

  task automatic step();
    logic [3:0] e_en, e_clr;
    bit e_pc, e_ack, bact, brm, fl, go_flush;
    @(negedge clk);
    brm  = branch_hazard | mret_type;
    bact = load_hazard || (bub_left > 0);
    e_ack = 0;
    if (reset) begin
      e_en = 4'b0000; e_clr = 4'b1111; e_pc = 0;
    end else if (flushing) begin
      e_en = 4'b1111; e_clr = 4'b1111; e_pc = 1;
      e_ack = 1;
    end else begin
      if (brm) begin
        e_clr = 4'b0111; e_pc = 1;
        e_en  = stall_pipl ? 4'b0000 : 4'b1111;
      end else if (stall_pipl) begin
        e_en = 4'b0000; e_clr = 4'b0000; e_pc = 0;
      end else if (bact) begin
        e_en = 4'b1110; e_clr = 4'b0010; e_pc = 0;
      end else begin
        e_en = 4'b1111; e_clr = 4'b0000;
        e_pc = !stall_compressed;
      end
      if (hw_jump_clr) e_clr[1] = 1'b1;
    end
    obs_en   = reg_en;
    obs_clr  = reg_clr;
    obs_pc   = pc_reg_en;
    obs_ack  = irq_ack;
    obs_cnt  = flush_count;
    obs_cnt2 = flush_count2;
    chk("reg_en", reg_en, e_en);
    chk("reg_clr", reg_clr, e_clr);
    chk("pc_reg_en", pc_reg_en, e_pc);
    chk("irq_ack", irq_ack, e_ack);
    chk("reg_en_w2", reg_en2, e_en);
    chk("reg_clr_w2", reg_clr2, e_clr);
    chk("pc_reg_en_w2", pc_reg_en2, e_pc);
    chk("irq_ack_w2", irq_ack2, e_ack);
    if (known) begin
      chk("flush_count", flush_count, fc16);
      chk("flush_count_w2", flush_count2, fc2);
    end
    last_ack = e_ack;
    if (reset) begin
      bub_left = 0; draining = 0; flushing = 0;
      fc16 = 0; fc2 = 0; known = 1;
    end else begin
      fl = brm || flushing;
      if (fl) bub_left = 0;
      else if (!stall_pipl) begin
        if (bub_left > 0) bub_left--;
        else if (load_hazard) bub_left = 3 - 1;
      end
      if (fl) begin
        if (fc16 < 65535) fc16++;
        if (fc2 < 3) fc2++;
      end
      go_flush = 0;
      if (flushing) draining = 0;
      else if (draining) begin
        if (!irq_req) draining = 0;
        else if (!stall_pipl && !bact && !brm) begin
          draining = 0; go_flush = 1;
        end
      end else if (irq_req) draining = 1;
      flushing = go_flush;
    end
    @(posedge clk);
    #1;
  endtask

  int seq2 [5] = '{1, 2, 3, 3, 3};

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_clr", obs_clr, 4'b1111);
    chk("rst_en", obs_en, 4'b0000);
    chk("rst_pc", obs_pc, 1'b0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("idle_en", obs_en, 4'b1111);
    chk("idle_pc", obs_pc, 1'b1);
    chk("idle_cnt", obs_cnt, 16'd0);

    drv(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("bub_en", obs_en, k < 3 ? 4'b1110 : 4'b1111);
      chk("bub_clr", obs_clr, k < 3 ? 4'b0010 : 4'b0000);
      chk("bub_pc", obs_pc, k < 3 ? 1'b0 : 1'b1);
    end

    drv(0, 1, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("stl_en", obs_en, 4'b0000);
      chk("stl_clr", obs_clr, 4'b0000);
    end
    drv(0, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      chk("rel_en", obs_en, k < 3 ? 4'b1110 : 4'b1111);
    end

    drv(0, 1, 0, 0, 0, 1, 0, 0);
    repeat (4) step();
    chk("drain_ack", obs_ack, 1'b0);
    drv(0, 0, 0, 0, 0, 1, 0, 0);
    step();
    chk("drain_last_ack", obs_ack, 1'b0);
    step();
    chk("flush_ack", obs_ack, 1'b1);
    chk("flush_clr", obs_clr, 4'b1111);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("flush_cnt", obs_cnt, 16'd1);
    chk("post_ack", obs_ack, 1'b0);

    drv(0, 0, 1, 1, 0, 0, 0, 0);
    step();
    chk("brld_clr", obs_clr, 4'b0111);
    chk("brld_pc", obs_pc, 1'b1);
    chk("brld_en", obs_en, 4'b1111);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("brld_nobub_en", obs_en, 4'b1111);
    chk("brld_nobub_pc", obs_pc, 1'b1);
    chk("brld_cnt", obs_cnt, 16'd2);

    drv(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    drv(0, 0, 0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k > 0) chk("sat_cnt2", obs_cnt2, seq2[k-1]);
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("sat_cnt2", obs_cnt2, seq2[4]);

    for (int n = 0; n < 3000; n++) begin
      reset            = ($urandom_range(0, 199) == 0);
      stall_pipl       = ($urandom_range(0, 99) < 20);
      load_hazard      = ($urandom_range(0, 99) < 15);
      branch_hazard    = ($urandom_range(0, 99) < 8);
      mret_type        = ($urandom_range(0, 99) < 3);
      hw_jump_clr      = ($urandom_range(0, 99) < 5);
      stall_compressed = ($urandom_range(0, 99) < 10);
      if (last_ack) irq_req = 0;
      else if (!irq_req && $urandom_range(0, 29) == 0)
        irq_req = 1;
      else if (irq_req && $urandom_range(0, 99) == 0)
        irq_req = 0;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
